// File: rtl/cond_exec_stage.sv
// EX->MEM boundary: NZCV flag register, ARM condition evaluation and write gating.
// Define COND_EXEC_STAGE_PERF_EN to add the ExecCount/SquashCount performance counters.
module cond_exec_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             ValidE,
  input  logic [3:0]       CondE,
  input  logic [1:0]       FlagWriteE,
  input  logic             PCSE,
  input  logic             RegWE,
  input  logic             MemWE,
  input  logic             LongWE,
  input  logic [3:0]       ALUFlags,
  input  logic [WIDTH-1:0] ResultE,
  input  logic [WIDTH-1:0] LongE,
  input  logic [RA_W-1:0]  WA3E,
  input  logic [RA_W-1:0]  WA4E,
  output logic             ValidM,
  output logic             PCSrcM,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             LongWriteM,
  output logic             UndefM,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] LongM,
  output logic [RA_W-1:0]  WA3M,
  output logic [RA_W-1:0]  WA4M,
  output logic [3:0]       Flags
`ifdef COND_EXEC_STAGE_PERF_EN
  ,
  output logic [31:0]      ExecCount,
  output logic [31:0]      SquashCount
`endif
);

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_ex, exec, load;

  assign {flag_n, flag_z, flag_c, flag_v} = Flags;

  // Condition is evaluated against the flags before this instruction's own update.
  always_comb begin
    cond_ex = 1'b0;
    case (CondE)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign exec = ValidE & cond_ex;
  assign load = ~Stall & ~Flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ValidM     <= 1'b0;
      PCSrcM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      LongWriteM <= 1'b0;
      UndefM     <= 1'b0;
    end else if (!Stall) begin
      ValidM     <= load & ValidE;
      PCSrcM     <= load & PCSE & exec;
      RegWriteM  <= load & RegWE & exec;
      MemWriteM  <= load & MemWE & exec;
      LongWriteM <= load & LongWE & exec;
      UndefM     <= load & ValidE & (CondE == 4'b1111);
    end
  end

  // Data and addresses are don't-care behind a bubble, so they load even on flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ALUResultM <= '0;
      LongM      <= '0;
      WA3M       <= '0;
      WA4M       <= '0;
    end else if (!Stall) begin
      ALUResultM <= ResultE;
      LongM      <= LongE;
      WA3M       <= WA3E;
      WA4M       <= WA4E;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Flags <= 4'b0000;
    end else if (load) begin
      if (FlagWriteE[1] & exec) Flags[3:2] <= ALUFlags[3:2];
      if (FlagWriteE[0] & exec) Flags[1:0] <= ALUFlags[1:0];
    end
  end

`ifdef COND_EXEC_STAGE_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ExecCount   <= 32'd0;
      SquashCount <= 32'd0;
    end else if (load) begin
      if (exec)               ExecCount   <= ExecCount + 32'd1;
      if (ValidE & ~cond_ex)  SquashCount <= SquashCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed bench for cond_exec_stage with hand-computed expectations.
// Exercises the perf counters too when COND_EXEC_STAGE_PERF_EN is defined.
module tb_cond_exec_stage;

  localparam int WIDTH = 32;
  localparam int RA_W  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             Stall, Flush, ValidE, PCSE, RegWE, MemWE, LongWE;
  logic [3:0]       CondE, ALUFlags;
  logic [1:0]       FlagWriteE;
  logic [WIDTH-1:0] ResultE, LongE;
  logic [RA_W-1:0]  WA3E, WA4E;
  logic             ValidM, PCSrcM, RegWriteM, MemWriteM, LongWriteM, UndefM;
  logic [WIDTH-1:0] ALUResultM, LongM;
  logic [RA_W-1:0]  WA3M, WA4M;
  logic [3:0]       Flags;
`ifdef COND_EXEC_STAGE_PERF_EN
  logic [31:0]      ExecCount, SquashCount;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cond_exec_stage #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .ValidE(ValidE),
    .CondE(CondE), .FlagWriteE(FlagWriteE), .PCSE(PCSE), .RegWE(RegWE),
    .MemWE(MemWE), .LongWE(LongWE), .ALUFlags(ALUFlags), .ResultE(ResultE),
    .LongE(LongE), .WA3E(WA3E), .WA4E(WA4E), .ValidM(ValidM), .PCSrcM(PCSrcM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .LongWriteM(LongWriteM),
    .UndefM(UndefM), .ALUResultM(ALUResultM), .LongM(LongM), .WA3M(WA3M),
    .WA4M(WA4M), .Flags(Flags)
`ifdef COND_EXEC_STAGE_PERF_EN
    , .ExecCount(ExecCount), .SquashCount(SquashCount)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // valid, cond, flagwrite, {pcs,regw,memw,longw}, aluflags
  task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                       input logic [3:0] we, input logic [3:0] af);
    ValidE = v; CondE = c; FlagWriteE = fw;
    {PCSE, RegWE, MemWE, LongWE} = we;
    ALUFlags = af;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; Stall = 1'b0; Flush = 1'b0;
    ResultE = '0; LongE = '0; WA3E = '0; WA4E = '0;
    drive(1'b0, 4'h0, 2'b00, 4'b0000, 4'h0);

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(($urandom)), 2'($urandom), 4'($urandom), 4'($urandom));
      ResultE = $urandom; LongE = $urandom; WA3E = 4'($urandom); WA4E = 4'($urandom);
      Stall = 1'($urandom); Flush = 1'($urandom);
      step();
    end
    check("rst_valid", 32'(ValidM), 32'd0);
    check("rst_regw", 32'(RegWriteM), 32'd0);
    check("rst_result", ALUResultM, 32'd0);
    check("rst_long", LongM, 32'd0);
    check("rst_flags", 32'(Flags), 32'd0);
    check("rst_undef", 32'(UndefM), 32'd0);

    reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    drive(1'b1, 4'hE, 2'b00, 4'b0100, 4'h0);
    ResultE = 32'h1234; LongE = 32'h0; WA3E = 4'd3; WA4E = 4'd0;
    step();
    check("first_regw", 32'(RegWriteM), 32'd1);
    check("first_result", ALUResultM, 32'h1234);
    check("first_valid", 32'(ValidM), 32'd1);
    check("first_wa3", 32'(WA3M), 32'd3);

    drive(1'b1, 4'hE, 2'b11, 4'b0000, 4'b0100);   // SUBS setting Z
    step();
    check("subs_flags", 32'(Flags), 32'h4);

    drive(1'b1, 4'h0, 2'b00, 4'b0100, 4'h0);      // EQ
    step();
    check("eq_regw", 32'(RegWriteM), 32'd1);

    drive(1'b1, 4'h1, 2'b00, 4'b0100, 4'h0);      // NE
    step();
    check("ne_regw", 32'(RegWriteM), 32'd0);
    check("ne_valid", 32'(ValidM), 32'd1);

    drive(1'b1, 4'hE, 2'b11, 4'b0000, 4'hF);
    step();
    check("flags_all", 32'(Flags), 32'hF);
    drive(1'b1, 4'hE, 2'b10, 4'b0000, 4'h0);      // NZ only
    step();
    check("partial_nz", 32'(Flags), 32'h3);
    drive(1'b1, 4'hE, 2'b01, 4'b0100, 4'hC);      // CV only: C=0,V=0
    ResultE = 32'hAAAA;
    step();
    check("partial_cv", 32'(Flags), 32'h0);
    drive(1'b1, 4'hE, 2'b11, 4'b0100, 4'h3);
    step();
    check("flags_cv", 32'(Flags), 32'h3);

    Stall = 1'b1; Flush = 1'b1;
    drive(1'b0, 4'hE, 2'b11, 4'b0000, 4'h0);
    ResultE = 32'h5555;
    step();
    check("stall_valid", 32'(ValidM), 32'd1);
    check("stall_regw", 32'(RegWriteM), 32'd1);
    check("stall_result", ALUResultM, 32'hAAAA);
    check("stall_flags", 32'(Flags), 32'h3);

    Stall = 1'b0; Flush = 1'b1;
    drive(1'b1, 4'hE, 2'b11, 4'b0010, 4'hA);
    step();
    check("flush_memw", 32'(MemWriteM), 32'd0);
    check("flush_valid", 32'(ValidM), 32'd0);
    check("flush_flags", 32'(Flags), 32'h3);
    Flush = 1'b0;

    drive(1'b1, 4'hE, 2'b11, 4'b0000, 4'b1000);   // N=1 V=0
    step();
    drive(1'b1, 4'hB, 2'b00, 4'b0100, 4'h0);      // LT
    step();
    check("lt_regw", 32'(RegWriteM), 32'd1);
    drive(1'b1, 4'hA, 2'b00, 4'b0100, 4'h0);      // GE
    step();
    check("ge_regw", 32'(RegWriteM), 32'd0);

    drive(1'b1, 4'hE, 2'b11, 4'b0000, 4'b1001);   // N=1 Z=0 C=0 V=1
    step();
    drive(1'b1, 4'hC, 2'b00, 4'b0100, 4'h0);      // GT
    step();
    check("gt_regw", 32'(RegWriteM), 32'd1);
    drive(1'b1, 4'h8, 2'b00, 4'b0100, 4'h0);      // HI, C=0
    step();
    check("hi_regw", 32'(RegWriteM), 32'd0);
    drive(1'b1, 4'h9, 2'b00, 4'b1011, 4'h0);      // LS with PC, store, long
    LongE = 32'hDEAD_BEEF; WA4E = 4'd9;
    step();
    check("ls_pcsrc", 32'(PCSrcM), 32'd1);
    check("ls_memw", 32'(MemWriteM), 32'd1);
    check("ls_longw", 32'(LongWriteM), 32'd1);
    check("ls_long", LongM, 32'hDEAD_BEEF);
    check("ls_wa4", 32'(WA4M), 32'd9);

    drive(1'b1, 4'hF, 2'b11, 4'b0100, 4'h0);      // undefined condition
    step();
    check("undef_undef", 32'(UndefM), 32'd1);
    check("undef_regw", 32'(RegWriteM), 32'd0);
    check("undef_flags", 32'(Flags), 32'h9);

    drive(1'b0, 4'hE, 2'b11, 4'b1111, 4'h6);      // bubble from EX
    step();
    check("inval_valid", 32'(ValidM), 32'd0);
    check("inval_undef", 32'(UndefM), 32'd0);
    check("inval_regw", 32'(RegWriteM), 32'd0);
    check("inval_flags", 32'(Flags), 32'h9);

    drive(1'b1, 4'hE, 2'b00, 4'b0100, 4'h0);
    step();
    Stall = 1'b1; Flush = 1'b1;
    #3 reset = 1'b0;
    #1;
    check("async_valid", 32'(ValidM), 32'd0);
    check("async_flags", 32'(Flags), 32'd0);
    check("async_result", ALUResultM, 32'd0);
    step();
    reset = 1'b1; Stall = 1'b0; Flush = 1'b0;

`ifdef COND_EXEC_STAGE_PERF_EN
    check("perf_rst_exec", ExecCount, 32'd0);
    drive(1'b1, 4'hE, 2'b00, 4'b0100, 4'h0); step();
    drive(1'b1, 4'h0, 2'b00, 4'b0100, 4'h0); step();   // Z=0: squashed
    drive(1'b1, 4'hE, 2'b00, 4'b0100, 4'h0); step();
    drive(1'b1, 4'h4, 2'b00, 4'b0100, 4'h0); step();   // N=0: squashed
    drive(1'b0, 4'h0, 2'b00, 4'b0100, 4'h0); step();   // invalid: neither
    drive(1'b1, 4'hE, 2'b00, 4'b0100, 4'h0); step();
    Stall = 1'b1; step();
    Stall = 1'b0; Flush = 1'b1; step();
    Flush = 1'b0;
    check("perf_exec", ExecCount, 32'd3);
    check("perf_squash", SquashCount, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_exec_stage.md
Name: cond_exec_stage

Overview:
- Sits directly downstream of the ALU in the pipelined ARM datapath and consumes `Result`, `Long` and `ALUFlags`.
- Holds the architectural NZCV flags register and evaluates the instruction condition field against it.
- Gates register, memory and PC writes on the condition result.
- Registers everything into the EX/MEM pipeline boundary, with stall and flush control.

Parameters:
- WIDTH, 32, datapath width of ALU result and long-result words
- RA_W, 4, register-address width

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- Stall  input  1  hold the M-stage registers and flags
- Flush  input  1  load a bubble into the M stage
- ValidE  input  1  EX-stage instruction is valid
- CondE  input  4  ARM condition field
- FlagWriteE  input  2  [1]=update NZ, [0]=update CV
- PCSE  input  1  instruction writes the PC
- RegWE  input  1  instruction writes Rd
- MemWE  input  1  instruction is a store
- LongWE  input  1  instruction writes RdHi (SMUL/UMUL)
- ALUFlags  input  4  {N,Z,C,V} from the ALU
- ResultE  input  WIDTH  ALU Result
- LongE  input  WIDTH  ALU Long (high word)
- WA3E  input  RA_W  destination register
- WA4E  input  RA_W  high-word destination register
- ValidM  output  1  M stage holds a real instruction
- PCSrcM  output  1  gated PC write
- RegWriteM  output  1  gated register write
- MemWriteM  output  1  gated store
- LongWriteM  output  1  gated RdHi write
- UndefM  output  1  CondE was 4'b1111 on a valid instruction
- ALUResultM  output  WIDTH  registered ResultE
- LongM  output  WIDTH  registered LongE
- WA3M  output  RA_W  registered WA3E
- WA4M  output  RA_W  registered WA4E
- Flags  output  4  architectural NZCV register

Behaviour:
- Reset (reset=0, asynchronous):
  - All M outputs and Flags go to 0.
  - Reset mid-stall or mid-flush wins immediately.
- CondEx is combinational from CondE and the current Flags register (pre-update value):
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z
  - 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1
  - 1111: CondEx=0, and UndefM is set on load.
- Exec = ValidE & CondEx.
- Update priority per clock edge:
  1. Stall=1: every register holds, including Flags, regardless of Flush.
  2. Flush=1 (Stall=0): ValidM, PCSrcM, RegWriteM, MemWriteM, LongWriteM and UndefM load 0. Data and address registers may load any value. Flags do not update.
  3. Otherwise, load:
     - ValidM = ValidE
     - PCSrcM = PCSE & Exec; RegWriteM = RegWE & Exec; MemWriteM = MemWE & Exec; LongWriteM = LongWE & Exec
     - UndefM = ValidE & (CondE==4'b1111)
     - Data and address registers load their E-stage values unconditionally.
     - Flags[3:2] <= ALUFlags[3:2] if FlagWriteE[1] & Exec.
     - Flags[1:0] <= ALUFlags[1:0] if FlagWriteE[0] & Exec.
- Latency: one cycle from E inputs to M outputs.
- Back-to-back timing: the flag update from instruction i is visible to the condition of instruction i+1 in the next cycle. No forwarding is needed.
- A failed-condition instruction keeps ValidM=1 but all write enables 0.
- ValidE=0 behaves like a failed condition: no flag update, all enables 0.

Optional Feature:
- Macro: COND_EXEC_STAGE_PERF_EN.
- With the macro defined, two extra outputs are present:
  - ExecCount, 32 bits: increments on each non-stalled, non-flushed edge where Exec=1.
  - SquashCount, 32 bits: increments on the same edges where ValidE=1 and CondEx=0.
  - Both wrap at 2^32 and reset to 0.
- Without the macro the ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- Reset: reset=0 with random inputs -> all outputs 0 and Flags=0000. Deassert, then ValidE=1, CondE=1110, RegWE=1, ResultE=32'h1234 -> next cycle RegWriteM=1, ALUResultM=32'h1234.
- Flag write then condition: cycle 0 SUBS (FlagWriteE=11, ALUFlags=0100, AL) -> Flags=0100. Cycle 1 CondE=0000 (EQ), RegWE=1 -> RegWriteM=1. Same with CondE=0001 -> RegWriteM=0, ValidM=1.
- Partial flag write: Flags=1111, then FlagWriteE=10 with ALUFlags=0000 -> Flags=0011.
- Stall and flush: Stall=1 with Flush=1 -> all M outputs and Flags unchanged. Next cycle Stall=0, Flush=1, MemWE=1, AL -> MemWriteM=0, ValidM=0, Flags unchanged.
- Signed conditions: Flags N=1,V=0 -> LT executes, GE squashed. Flags N=1,V=1,Z=0 -> GT executes.
- Undef: ValidE=1, CondE=1111, RegWE=1 -> UndefM=1, RegWriteM=0.
- With COND_EXEC_STAGE_PERF_EN: after 3 executed and 2 squashed instructions -> ExecCount=3, SquashCount=2.
